// File: rtl/vga_timing_stream.sv
// vga_timing_stream: turns a pixel stream (valid/ready/sop) into VGA-style
// video timing. Free-running h/v counters set the raster; a two-state FSM
// keeps the incoming stream aligned to the frame origin. It reports starved
// pixels (underflow) and frame misalignment (sop_error).
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_valid is never gated by in_ready. in_ready is combinational from the
// current raster position, the FSM state and in_valid/in_sop. It is held low
// while reset is asserted, so no beat is consumed during reset.
module vga_timing_stream #(
  parameter int DATA_W   = 24,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  output logic              in_ready,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_de,
  output logic              vid_hs,
  output logic              vid_vs,
  output logic              locked,
  output logic              underflow,
  output logic              sop_error,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  // Region boundaries are compared at 32 bits so a zero back porch
  // (boundary == total) cannot wrap inside the narrow counter width.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] HS_BEGIN  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] VS_BEGIN  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    LOCKED    = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [H_W-1:0]    h_cnt_q, h_cnt_d;
  logic [V_W-1:0]    v_cnt_q, v_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_de_q, vid_de_d;
  logic              vid_hs_q, vid_hs_d;
  logic              vid_vs_q, vid_vs_d;
  logic              underflow_q, underflow_d;
  logic              sop_error_q, sop_error_d;

  logic [31:0] h_pos, v_pos;
  logic        h_last, v_last, frame_end;
  logic        active, hsync, vsync, origin;
  logic        beat_err;
  logic        ready_raw;
  logic        take;

  // Raster position: h wraps every line, v advances on h wrap, frame count on full wrap
  always_comb begin
    h_last      = (h_cnt_q == H_LAST);
    v_last      = (v_cnt_q == V_LAST);
    frame_end   = h_last && v_last;
    h_cnt_d     = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
    frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Region decode of the current position, plus stream/raster misalignment check
  always_comb begin
    h_pos    = 32'(h_cnt_q);
    v_pos    = 32'(v_cnt_q);
    active   = (h_pos < H_ACT_END) && (v_pos < V_ACT_END);
    hsync    = (h_pos >= HS_BEGIN) && (h_pos < HS_END);
    vsync    = (v_pos >= VS_BEGIN) && (v_pos < VS_END);
    origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
    // A valid beat whose sop flag disagrees with "this is pixel (0,0)"
    beat_err = in_valid && active && (origin ? !in_sop : in_sop);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNC_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on an sop beat at origin, drop lock on misalignment
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC_WAIT: if (origin && in_valid && in_sop) state_d = LOCKED;
      LOCKED:    if (beat_err) state_d = SYNC_WAIT;
      default:   state_d = SYNC_WAIT;
    endcase
  end

  // FSM outputs: ready, which beat becomes a pixel, and the status pulses
  always_comb begin
    ready_raw   = 1'b0;
    take        = 1'b0;
    underflow_d = 1'b0;
    sop_error_d = 1'b0;
    locked      = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        // Non-sop beats are drained; an sop beat waits for the origin.
        ready_raw = in_valid && (!in_sop || origin);
        take      = in_valid && in_sop && origin && active;
      end
      LOCKED: begin
        locked      = 1'b1;
        ready_raw   = active && !beat_err;
        take        = active && in_valid && !beat_err;
        sop_error_d = beat_err;
        // beat_err needs in_valid, underflow needs !in_valid: never both.
        underflow_d = active && !in_valid;
      end
      default: begin
        ready_raw = 1'b0;
      end
    endcase
    in_ready = ready_raw && !reset;
  end

  // Next video outputs: one-cycle registered view of the current position
  always_comb begin
    vid_data_d = take ? in_data : '0;
    vid_de_d   = active;
    vid_hs_d   = hsync ? HS_ACT : ~HS_ACT;
    vid_vs_d   = vsync ? VS_ACT : ~VS_ACT;
  end

  // Counter and video output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      vid_data_q  <= '0;
      vid_de_q    <= 1'b0;
      vid_hs_q    <= ~HS_ACT;
      vid_vs_q    <= ~VS_ACT;
      underflow_q <= 1'b0;
      sop_error_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vid_data_q  <= vid_data_d;
      vid_de_q    <= vid_de_d;
      vid_hs_q    <= vid_hs_d;
      vid_vs_q    <= vid_vs_d;
      underflow_q <= underflow_d;
      sop_error_q <= sop_error_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_de    = vid_de_q;
  assign vid_hs    = vid_hs_q;
  assign vid_vs    = vid_vs_q;
  assign underflow = underflow_q;
  assign sop_error = sop_error_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_stream.sv
// tb_vga_timing_stream: directed test of vga_timing_stream on a tiny raster
// (H 4/1/2/1, V 3/1/1/1 -> 8 x 6 = 48 cycles per frame, active-low syncs).
// A "slot" is one raster position. The bench drives its inputs just after
// a rising edge. It reads in_ready at the falling edge inside the slot, and
// reads the registered outputs for that slot 1 time unit after the next
// rising edge.
module tb_vga_timing_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic [23:0] vid_data;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;
  logic        locked;
  logic        underflow;
  logic        sop_error;
  logic [15:0] frame_cnt;

  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_frames = 0;
  logic rdy_s;

  vga_timing_stream #(
    .DATA_W(24),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_sop(in_sop),
    .in_ready(in_ready),
    .vid_data(vid_data),
    .vid_de(vid_de),
    .vid_hs(vid_hs),
    .vid_vs(vid_vs),
    .locked(locked),
    .underflow(underflow),
    .sop_error(sop_error),
    .frame_cnt(frame_cnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected raster regions for slot c of a frame (c = 0 is the origin)
  function automatic logic exp_act(input int c);
    return ((c % 8) < 4) && ((c / 8) < 3);
  endfunction

  function automatic logic exp_hs(input int c);
    return !(((c % 8) == 5) || ((c % 8) == 6));
  endfunction

  function automatic logic exp_vs(input int c);
    return !((c / 8) == 4);
  endfunction

  function automatic logic [23:0] pix(input int i);
    return 24'hC00000 + 24'(i);
  endfunction

  // driver tasks
  task automatic slot(input logic v, input logic s, input logic [23:0] d);
    in_valid = v;
    in_sop   = s;
    in_data  = d;
    @(negedge clk);
    rdy_s = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_timing(input string pfx, input int c);
    chk({pfx, " de"}, 32'(vid_de), 32'(exp_act(c)));
    chk({pfx, " hs"}, 32'(vid_hs), 32'(exp_hs(c)));
    chk({pfx, " vs"}, 32'(vid_vs), 32'(exp_vs(c)));
  endtask

  // One reset edge with a beat held on the inputs; checks the reset values
  task automatic do_reset(input logic hold_v, input logic hold_s);
    reset    = 1'b1;
    in_valid = hold_v;
    in_sop   = hold_s;
    in_data  = pix(77);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    chk("rst vid_data", 32'(vid_data), 32'd0);
    chk("rst vid_de", 32'(vid_de), 32'd0);
    chk("rst vid_hs", 32'(vid_hs), 32'd1);
    chk("rst vid_vs", 32'(vid_vs), 32'd1);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst underflow", 32'(underflow), 32'd0);
    chk("rst sop_error", 32'(sop_error), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    exp_frames = 0;
  endtask

  // Streams pixel-indexed data into active slots, sop on pixel 0.
  // drop_px: pixel with in_valid low; err_px: pixel with a stray sop (-1 = none).
  task automatic frame(input int drop_px, input int err_px, input logic start_locked,
                       input int n_slots);
    int   c_err;
    int   idx;
    logic act, lb, vld, sp, shown;
    logic exp_rdy;
    string pfx;
    c_err = (err_px >= 0) ? (err_px / 4) * 8 + (err_px % 4) : 1000;
    for (int c = 0; c < n_slots; c++) begin
      idx = (c / 8) * 4 + (c % 8);
      act = exp_act(c);
      lb  = (c == 0) ? start_locked : (c <= c_err);
      vld = act && (idx != drop_px);
      sp  = act && ((idx == 0) || (idx == err_px));
      slot(vld, sp, act ? pix(idx) : 24'h0);
      if (!act)          exp_rdy = 1'b0;
      else if (c == 0)   exp_rdy = 1'b1;
      else if (lb)       exp_rdy = (c != c_err);
      else               exp_rdy = vld && !sp;
      shown = act && ((c == 0) || (lb && (idx != drop_px) && (c != c_err)));
      pfx = $sformatf("f%0d c%0d", exp_frames, c);
      chk({pfx, " in_ready"}, 32'(rdy_s), 32'(exp_rdy));
      chk({pfx, " vid_data"}, 32'(vid_data), shown ? 32'(pix(idx)) : 32'd0);
      chk({pfx, " underflow"}, 32'(underflow), 32'(lb && act && (idx == drop_px)));
      chk({pfx, " sop_error"}, 32'(sop_error), 32'(c == c_err));
      chk({pfx, " locked"}, 32'(locked), 32'(c < c_err));
      chk_timing(pfx, c);
    end
    if (n_slots == 48) exp_frames++;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
  endtask

  initial begin
    int n_de, n_hsl, n_vsl;
    string pfx;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;

    // reset with an sop beat held at the origin: must not be consumed
    do_reset(1'b1, 1'b1);

    // idle raster: sync/de pattern and frame count
    n_de = 0; n_hsl = 0; n_vsl = 0;
    for (int c = 0; c < 48; c++) begin
      slot(1'b0, 1'b0, 24'h0);
      pfx = $sformatf("idle c%0d", c);
      chk_timing(pfx, c);
      chk({pfx, " vid_data"}, 32'(vid_data), 32'd0);
      chk({pfx, " in_ready"}, 32'(rdy_s), 32'd0);
      chk({pfx, " underflow"}, 32'(underflow), 32'd0);
      chk({pfx, " locked"}, 32'(locked), 32'd0);
      if (c == 46) chk("idle frame_cnt pre", 32'(frame_cnt), 32'd0);
      n_de  += int'(vid_de);
      n_hsl += int'(!vid_hs);
      n_vsl += int'(!vid_vs);
    end
    chk("idle frame_cnt", 32'(frame_cnt), 32'd1);
    chk("idle de count", 32'(n_de), 32'd12);
    chk("idle hs low count", 32'(n_hsl), 32'd12);
    chk("idle vs low count", 32'(n_vsl), 32'd8);

    // continuous stream over three frames
    do_reset(1'b0, 1'b0);
    frame(-1, -1, 1'b0, 48);
    frame(-1, -1, 1'b1, 48);
    frame(-1, -1, 1'b1, 48);

    // two junk beats, then an sop beat held from (3,0) to the next origin
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 48; c++) begin
      pfx = $sformatf("junk c%0d", c);
      if (c == 0) slot(1'b0, 1'b0, 24'h0);
      else if (c < 3) slot(1'b1, 1'b0, pix(90 + c));
      else slot(1'b1, 1'b1, pix(0));
      chk({pfx, " in_ready"}, 32'(rdy_s), 32'((c == 1) || (c == 2)));
      chk({pfx, " vid_data"}, 32'(vid_data), 32'd0);
      chk({pfx, " underflow"}, 32'(underflow), 32'd0);
      chk({pfx, " sop_error"}, 32'(sop_error), 32'd0);
      chk({pfx, " locked"}, 32'(locked), 32'd0);
      chk_timing(pfx, c);
    end
    exp_frames = 1;
    chk("junk frame_cnt", 32'(frame_cnt), 32'd1);
    frame(-1, -1, 1'b0, 48);

    // starved pixel (2,1) while locked
    frame(6, -1, 1'b1, 48);

    // stray sop on pixel (1,2), then relock at the next origin
    frame(-1, 9, 1'b1, 48);
    frame(-1, -1, 1'b0, 48);

    // reset at cycle 20 of a locked frame, then relock
    frame(-1, -1, 1'b1, 20);
    do_reset(1'b1, 1'b1);
    frame(-1, -1, 1'b0, 48);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
